pha_acq_ctrl: RTL

- Run controller for the pulse-height analysis chain.
- Arms and gates the pulse-height front end, applies a dead-time/pile-up window and an energy window (LLD/ULD) to each pulse-height strobe, and hands accepted heights to the histogram writer over valid/ready.
- Counts live time against a preset, real time, and accepted/rejected events.
- Sits between the pulse-height front end and the histogram memory writer.

---
 rtl/pha_pkg.sv | 15 +
 rtl/pha_tick_gen.sv | 33 +++
 rtl/pha_acq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pha_pkg.sv
// rtl/pha_pkg.sv - shared state encoding and width defaults for the PHA run controller
package pha_pkg;

  localparam int PHA_DATA_W = 14;
  localparam int PHA_TIME_W = 24;
  localparam int PHA_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DEAD  = 2'd2,
    ST_DONE  = 2'd3
  } pha_state_e;

endpackage

// File: rtl/pha_tick_gen.sv
// rtl/pha_tick_gen.sv - gated prescaler producing a one-cycle time tick
module pha_tick_gen
  import pha_pkg::*;
#(
  parameter int TICK_DIV = 65000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;

  // Tick fires in the cycle the prescaler sits on its last count while enabled.
  assign tick_o = en_i && (cnt_q == LAST);

  // Prescaler: cleared on run start, frozen while disabled, wraps after LAST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/pha_acq_ctrl.sv
// rtl/pha_acq_ctrl.sv - PHA run controller: arming, dead time, energy window, event handoff, counters
module pha_acq_ctrl
  import pha_pkg::*;
#(
  parameter int DATA_W      = PHA_DATA_W,
  parameter int TICK_DIV    = 65000,
  parameter int DEAD_CYCLES = 32,
  parameter int CNT_W       = PHA_CNT_W,
  parameter int TIME_W      = PHA_TIME_W
) (
  input  logic              CLOCK_65,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              cmd_clear,
  input  logic [TIME_W-1:0] preset_live,
  input  logic [DATA_W-1:0] lld,
  input  logic [DATA_W-1:0] uld,
  input  logic              ph_valid,
  input  logic [DATA_W-1:0] ph_data,
  output logic              pha_enable,
  output logic              ev_valid,
  output logic [DATA_W-1:0] ev_data,
  input  logic              ev_ready,
  output logic [TIME_W-1:0] live_time,
  output logic [TIME_W-1:0] real_time,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  rej_cnt,
  output logic              running,
  output logic              done
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]     DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};

  pha_state_e        state_q;
  logic [DW-1:0]     dead_q;
  logic              running_q, done_q;
  logic              ev_valid_q;
  logic [DATA_W-1:0] ev_data_q;
  logic [CNT_W-1:0]  acc_q, acc_d, rej_q, rej_d;
  logic [TIME_W-1:0] live_q, live_d, real_q, real_d;

  logic st_armed, st_active, st_parked;
  logic in_win, out_free, accept, reject;
  logic start_go, clear_go, tick, preset_hit;

  assign st_armed  = (state_q == ST_ARMED);
  assign st_active = st_armed || (state_q == ST_DEAD);
  assign st_parked = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // A pulse in ARMED is accepted only if in window and the output slot is free or draining now.
  assign in_win   = (ph_data >= lld) && (ph_data <= uld);
  assign out_free = !ev_valid_q || ev_ready;
  assign accept   = st_armed && ph_valid && in_win && out_free;
  assign reject   = st_active && ph_valid && !accept;

  assign start_go = st_parked && cmd_start;
  assign clear_go = st_parked && cmd_clear;

  pha_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i (CLOCK_65),
    .rst_i (rst),
    .en_i  (st_active),
    .clr_i (start_go),
    .tick_o(tick)
  );

  // Saturating event and time counters; clear wins since nothing else moves while parked.
  always_comb begin
    acc_d  = acc_q;
    rej_d  = rej_q;
    live_d = live_q;
    real_d = real_q;
    if (clear_go) begin
      acc_d  = '0;
      rej_d  = '0;
      live_d = '0;
      real_d = '0;
    end else begin
      if (accept && (acc_q != CNT_MAX)) acc_d = acc_q + CNT_W'(1);
      if (reject && (rej_q != CNT_MAX)) rej_d = rej_q + CNT_W'(1);
      if (tick && (real_q != TIME_MAX)) real_d = real_q + TIME_W'(1);
      if (tick && st_armed && (live_q != TIME_MAX)) live_d = live_q + TIME_W'(1);
    end
  end

  // Preset compares against the post-increment live time so DONE lands with live_time == preset.
  assign preset_hit = (preset_live != '0) && (live_d >= preset_live);

  // Run FSM with registered status flags, event output register and counter state.
  always_ff @(posedge CLOCK_65) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dead_q     <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
      acc_q      <= '0;
      rej_q      <= '0;
      live_q     <= '0;
      real_q     <= '0;
    end else begin
      acc_q  <= acc_d;
      rej_q  <= rej_d;
      live_q <= live_d;
      real_q <= real_d;

      if (accept) begin
        ev_valid_q <= 1'b1;
        ev_data_q  <= ph_data;
      end else if (ev_ready) begin
        ev_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_go) begin
            state_q   <= ST_ARMED;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (cmd_stop) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (ph_valid) begin
            state_q <= ST_DEAD;
            dead_q  <= DEAD_LOAD;
          end else if (preset_hit) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          if (cmd_stop || (!ph_valid && preset_hit)) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (ph_valid) begin
            dead_q <= DEAD_LOAD;
          end else if (dead_q == '0) begin
            state_q <= ST_ARMED;
          end else begin
            dead_q <= dead_q - DW'(1);
          end
        end
      endcase
    end
  end

  assign pha_enable = running_q;
  assign running    = running_q;
  assign done       = done_q;
  assign ev_valid   = ev_valid_q;
  assign ev_data    = ev_data_q;
  assign acc_cnt    = acc_q;
  assign rej_cnt    = rej_q;
  assign live_time  = live_q;
  assign real_time  = real_q;

endmodule
